// File: rtl/bus2to1_arbiter_pkg.sv
// Shared definitions for the simple valid/ready memory bus arbiter and its helpers.
package bus2to1_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Read data returned to a master whose transaction was forcibly completed.
  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } arb_state_e;

  // Watchdog counter width: enough to hold TIMEOUT, never narrower than one bit.
  function automatic int unsigned wd_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog: counts stalled owner cycles and flags the cycle in which
// the allowed wait is used up. TIMEOUT=0 disables it (expired stays low).
module bus_watchdog
  import bus2to1_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  input  logic hit,
  output logic expired
);

  localparam int unsigned CW = wd_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] count;

  // Stall counter: cleared while idle, advances on each enabled cycle without a hit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !hit && (TIMEOUT != 0)) begin
      count <= count + CW'(1);
    end
  end

  // Expiry is combinational so the forced completion lands in the last allowed cycle.
  always_comb begin
    expired = (TIMEOUT != 0) && enable && !hit && (count == LAST);
  end

endmodule

// File: rtl/bus2to1_arbiter.sv
// Two-initiator to one-responder round-robin arbiter with transaction-locked grant
// and optional watchdog forcing completion of hung transfers.
module bus2to1_arbiter
  import bus2to1_arbiter_pkg::*;
#(
  parameter int unsigned       TIMEOUT       = 0,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA = ERR_RDATA,
  parameter bit                M1_FIRST      = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,

  input  logic              m2_valid,
  output logic              m2_ready,
  input  logic [ADDR_W-1:0] m2_addr,
  output logic [DATA_W-1:0] m2_rdata,
  input  logic [DATA_W-1:0] m2_wdata,
  input  logic [STRB_W-1:0] m2_wstrb,

  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,

  output logic [1:0]        grant
);

  arb_state_e state, state_nxt;
  logic       prio, prio_nxt;     // 1: m1 wins a tie, 0: m2 wins a tie
  logic       owner_valid;
  logic       wd_expired;

  // Valid of whichever master currently owns the bus; low while idle.
  always_comb begin
    owner_valid = 1'b0;
    case (state)
      OWN1:    owner_valid = m1_valid;
      OWN2:    owner_valid = m2_valid;
      default: owner_valid = 1'b0;
    endcase
  end

  // The counter is held clear in IDLE, so it always starts from zero on grant.
  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state == IDLE),
    .enable  (owner_valid),
    .hit     (s_ready),
    .expired (wd_expired)
  );

  // State and round-robin priority registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      prio  <= M1_FIRST;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Arbitration, completion handling and the forwarding muxes, all from state.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    s_valid   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m1_ready  = 1'b0;
    m1_rdata  = '0;
    m2_ready  = 1'b0;
    m2_rdata  = '0;
    grant     = '0;
    unique case (state)
      IDLE: begin
        if (m1_valid && m2_valid) begin
          state_nxt = prio ? OWN1 : OWN2;
        end else if (m1_valid) begin
          state_nxt = OWN1;
        end else if (m2_valid) begin
          state_nxt = OWN2;
        end
      end
      OWN1: begin
        grant    = 2'b01;
        s_valid  = m1_valid && !wd_expired;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = m1_valid && (s_ready || wd_expired);
        m1_rdata = wd_expired ? TIMEOUT_RDATA : s_rdata;
        if (!m1_valid) begin
          state_nxt = IDLE;
        end else if (s_ready || wd_expired) begin
          state_nxt = IDLE;
          prio_nxt  = 1'b0;
        end
      end
      OWN2: begin
        grant    = 2'b10;
        s_valid  = m2_valid && !wd_expired;
        s_addr   = m2_addr;
        s_wdata  = m2_wdata;
        s_wstrb  = m2_wstrb;
        m2_ready = m2_valid && (s_ready || wd_expired);
        m2_rdata = wd_expired ? TIMEOUT_RDATA : s_rdata;
        if (!m2_valid) begin
          state_nxt = IDLE;
        end else if (s_ready || wd_expired) begin
          state_nxt = IDLE;
          prio_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus2to1_arbiter.sv
// Randomized bench for bus2to1_arbiter against a transaction-level reference model.
module tb_bus2to1_arbiter;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m1_valid, m1_ready, m2_valid, m2_ready;
  logic [31:0] m1_addr, m1_rdata, m1_wdata, m2_addr, m2_rdata, m2_wdata;
  logic [3:0]  m1_wstrb, m2_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_rdata, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  bus2to1_arbiter #(
    .TIMEOUT       (TO),
    .TIMEOUT_RDATA (ERR),
    .M1_FIRST      (1'b1)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_addr  (m1_addr),
    .m1_rdata (m1_rdata),
    .m1_wdata (m1_wdata),
    .m1_wstrb (m1_wstrb),
    .m2_valid (m2_valid),
    .m2_ready (m2_ready),
    .m2_addr  (m2_addr),
    .m2_rdata (m2_rdata),
    .m2_wdata (m2_wdata),
    .m2_wstrb (m2_wstrb),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_addr   (s_addr),
    .s_rdata  (s_rdata),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Master agents (index 1 = m1, 2 = m2)
  bit          req       [1:2];
  bit          got_ready [1:2];
  logic [31:0] ag_addr   [1:2];
  logic [31:0] ag_wdata  [1:2];
  logic [3:0]  ag_wstrb  [1:2];
  int unsigned rdy_pct, req_pct, viol_pct;

  // Reference model: current owner (0 = none), who wins a tie, stalled cycles so far
  int owner, turn, waited;
  bit m_tmo;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner  = 0;
    turn   = 1;
    waited = 0;
    m_tmo  = 1'b0;
  endtask

  task automatic drive_inputs();
    m1_valid = req[1];
    m1_addr  = ag_addr[1];
    m1_wdata = ag_wdata[1];
    m1_wstrb = ag_wstrb[1];
    m2_valid = req[2];
    m2_addr  = ag_addr[2];
    m2_wdata = ag_wdata[2];
    m2_wstrb = ag_wstrb[2];
  endtask

  task automatic new_request(input int i);
    req[i]      = 1'b1;
    ag_addr[i]  = $urandom;
    ag_wdata[i] = $urandom;
    ag_wstrb[i] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
  endtask

  task automatic agent_update();
    for (int i = 1; i <= 2; i++) begin
      bit dropped;
      dropped = 1'b0;
      if (req[i] && got_ready[i]) begin
        req[i] = 1'b0;
      end else if (req[i] && ($urandom_range(99) < viol_pct)) begin
        req[i]  = 1'b0;
        dropped = 1'b1;
      end
      if (!req[i] && !dropped && ($urandom_range(99) < req_pct)) new_request(i);
      got_ready[i] = 1'b0;
    end
    s_ready = ($urandom_range(99) < rdy_pct);
    s_rdata = $urandom;
    drive_inputs();
  endtask

  // Expected outputs from the model's view of ownership and the driven inputs.
  task automatic check_outputs();
    logic [31:0] e_sv, e_sa, e_sw, e_ss, e_gnt;
    logic [31:0] e_rdy [1:2];
    logic [31:0] e_rd  [1:2];
    e_sv = 0; e_sa = 0; e_sw = 0; e_ss = 0; e_gnt = 0;
    e_rdy[1] = 0; e_rdy[2] = 0; e_rd[1] = 0; e_rd[2] = 0;
    m_tmo = 1'b0;
    if (owner != 0) begin
      m_tmo       = req[owner] && !s_ready && (waited == int'(TO) - 1);
      e_sv        = 32'(req[owner] && !m_tmo);
      e_sa        = ag_addr[owner];
      e_sw        = ag_wdata[owner];
      e_ss        = 32'(ag_wstrb[owner]);
      e_rdy[owner] = 32'(req[owner] && (s_ready || m_tmo));
      e_rd[owner]  = m_tmo ? ERR : s_rdata;
      e_gnt       = 32'(1) << (owner - 1);
    end
    check_eq("s_valid",  32'(s_valid),  e_sv);
    check_eq("s_addr",   s_addr,        e_sa);
    check_eq("s_wdata",  s_wdata,       e_sw);
    check_eq("s_wstrb",  32'(s_wstrb),  e_ss);
    check_eq("m1_ready", 32'(m1_ready), e_rdy[1]);
    check_eq("m1_rdata", m1_rdata,      e_rd[1]);
    check_eq("m2_ready", 32'(m2_ready), e_rdy[2]);
    check_eq("m2_rdata", m2_rdata,      e_rd[2]);
    check_eq("grant",    32'(grant),    e_gnt);
    got_ready[1] = m1_ready;
    got_ready[2] = m2_ready;
  endtask

  task automatic advance_model();
    if (owner == 0) begin
      waited = 0;
      if (req[1] && req[2]) owner = turn;
      else if (req[1])      owner = 1;
      else if (req[2])      owner = 2;
    end else if (!req[owner]) begin
      owner = 0;
    end else if (s_ready || m_tmo) begin
      turn  = 3 - owner;
      owner = 0;
    end else begin
      waited++;
    end
  endtask

  // One bus cycle, entered and left at a falling edge.
  task automatic step();
    agent_update();
    #2;
    check_outputs();
    advance_model();
    @(negedge clk);
  endtask

  task automatic run_phase(input int unsigned rp, input int unsigned qp,
                           input int unsigned vp, input int n);
    rdy_pct  = rp;
    req_pct  = qp;
    viol_pct = vp;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    for (int i = 1; i <= 2; i++) begin
      req[i] = 1'b0; got_ready[i] = 1'b0;
      ag_addr[i] = '0; ag_wdata[i] = '0; ag_wstrb[i] = '0;
    end
    s_ready = 1'b0;
    s_rdata = '0;
    resetn  = 1'b0;
    drive_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    resetn = 1'b1;

    // m1 read held with a silent responder, then reset in the middle of it
    req[1] = 1'b1; ag_addr[1] = 32'h0000_0100; ag_wdata[1] = '0; ag_wstrb[1] = 4'h0;
    rdy_pct = 0; req_pct = 0; viol_pct = 0;
    step();
    step();
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs();

    // release with only m2 requesting a write
    req[1] = 1'b0;
    req[2] = 1'b1; ag_addr[2] = 32'h1000_0004; ag_wdata[2] = 32'hCAFE_F00D; ag_wstrb[2] = 4'b0011;
    drive_inputs();
    @(negedge clk);
    resetn = 1'b1;
    run_phase(0, 0, 0, 12);     // m2 stalls into the watchdog

    run_phase(100, 100, 0, 40); // continuous contention, always-ready responder
    run_phase(0, 60, 0, 80);    // responder never answers
    run_phase(30, 40, 2, 400);  // mixed traffic with occasional valid drops
    run_phase(8, 50, 2, 300);   // slow responder racing the watchdog

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
